coin_feeder: RTL and testbench

- Transmit-side driver for the snack vending machine's coin interface. It takes a payment request in nickel units and breaks it greedily into quarters, dimes and nickels.
- Coins go out as spaced single-cycle one-hot coin_in pulses.
- It then watches the machine's dispense, return and change outputs and reports the outcome of the transaction.
- Used as the coin-side front end in system tests and in the kiosk top level.

---
 rtl/vend_pkg.sv | 23 ++
 rtl/coin_picker.sv | 25 ++
 rtl/coin_feeder.sv | 195 +++++++++++++++++++
 tb/tb_coin_feeder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine coin interface: coin codes,
// coin values in nickel units and the coin_feeder state encoding.
package vend_pkg;

  localparam logic [2:0] COIN_NONE    = 3'b000;
  localparam logic [2:0] COIN_NICKEL  = 3'b001;
  localparam logic [2:0] COIN_DIME    = 3'b010;
  localparam logic [2:0] COIN_QUARTER = 3'b100;

  localparam int VAL_NICKEL  = 1;
  localparam int VAL_DIME    = 2;
  localparam int VAL_QUARTER = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_WAIT_RESP,
    ST_SETTLE,
    ST_DONE
  } feeder_state_e;

endpackage

// File: rtl/coin_picker.sv
// Greedy coin selector: largest coin not exceeding the remaining amount.
// A zero input yields a nickel; the caller only consults it when nonzero.
module coin_picker
  import vend_pkg::*;
#(
  parameter int AMT_W = 6
) (
  input  logic [AMT_W-1:0] remaining,
  output logic [2:0]       coin,
  output logic [AMT_W-1:0] value
);

  always_comb begin
    coin  = COIN_NICKEL;
    value = AMT_W'(VAL_NICKEL);
    if (remaining >= AMT_W'(VAL_QUARTER)) begin
      coin  = COIN_QUARTER;
      value = AMT_W'(VAL_QUARTER);
    end else if (remaining >= AMT_W'(VAL_DIME)) begin
      coin  = COIN_DIME;
      value = AMT_W'(VAL_DIME);
    end
  end

endmodule

// File: rtl/coin_feeder.sv
// Coin-side driver: pays a request as spaced one-hot coin pulses, then
// collects the machine's response and change and reports the outcome.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a request; results from the last one held
// PULSE     | coin_in carries one coin for this cycle
// GAP       | coin_in idle between coins
// WAIT_RESP | all coins sent, waiting for dispense/return or timeout
// SETTLE    | response seen, collecting change for a fixed window
// DONE      | one-cycle completion strobe
module coin_feeder
  import vend_pkg::*;
#(
  parameter int AMT_W       = 6,
  parameter int GAP_CYC     = 4,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int CHG_W       = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  output logic [2:0]       coin_in,
  input  logic             dispense_item,
  input  logic             out_return,
  input  logic             out_nickel,
  input  logic             out_dime,
  output logic             busy,
  output logic             done,
  output logic             done_dispensed,
  output logic             done_returned,
  output logic             done_timeout,
  output logic [CHG_W-1:0] change_total,
  output logic [3:0]       coins_sent
);

  localparam int TMR_MAX = (GAP_CYC > SETTLE_CYC)
                           ? ((GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC)
                           : ((SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC);
  localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] GAP_LOAD     = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  feeder_state_e    state_q, state_nx;
  logic [TMR_W-1:0] tmr_q, tmr_nx;
  logic [AMT_W-1:0] rem_q, rem_nx;
  logic [2:0]       coin_q, coin_nx;
  logic [3:0]       sent_q, sent_nx;
  logic             disp_q, disp_nx;
  logic             ret_q, ret_nx;
  logic             tmo_q, tmo_nx;
  logic [CHG_W-1:0] chg_q, chg_nx;

  logic [AMT_W-1:0] pick_src;
  logic [2:0]       pick_coin;
  logic [AMT_W-1:0] pick_val;
  logic             resp;
  logic [CHG_W:0]   chg_sum;
  logic [CHG_W-1:0] chg_sat;

  // In IDLE the first coin is chosen straight from the request amount.
  assign pick_src = (state_q == ST_IDLE) ? req_amount : rem_q;

  coin_picker #(.AMT_W(AMT_W)) u_picker (
    .remaining (pick_src),
    .coin      (pick_coin),
    .value     (pick_val)
  );

  // A response seen this cycle counts as latched so no extra coin slips out.
  assign resp    = disp_q | ret_q | dispense_item | out_return;
  assign chg_sum = {1'b0, chg_q} + (CHG_W+1)'({out_dime, out_nickel});
  assign chg_sat = chg_sum[CHG_W] ? {CHG_W{1'b1}} : chg_sum[CHG_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      rem_q   <= '0;
      coin_q  <= COIN_NONE;
      sent_q  <= '0;
      disp_q  <= 1'b0;
      ret_q   <= 1'b0;
      tmo_q   <= 1'b0;
      chg_q   <= '0;
    end else begin
      state_q <= state_nx;
      tmr_q   <= tmr_nx;
      rem_q   <= rem_nx;
      coin_q  <= coin_nx;
      sent_q  <= sent_nx;
      disp_q  <= disp_nx;
      ret_q   <= ret_nx;
      tmo_q   <= tmo_nx;
      chg_q   <= chg_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    tmr_nx   = tmr_q;
    rem_nx   = rem_q;
    coin_nx  = COIN_NONE;
    sent_nx  = sent_q;
    disp_nx  = disp_q;
    ret_nx   = ret_q;
    tmo_nx   = tmo_q;
    chg_nx   = chg_q;

    if (state_q != ST_IDLE) begin
      disp_nx = disp_q | dispense_item;
      ret_nx  = ret_q | out_return;
      chg_nx  = chg_sat;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          disp_nx = 1'b0;
          ret_nx  = 1'b0;
          tmo_nx  = 1'b0;
          chg_nx  = '0;
          sent_nx = '0;
          rem_nx  = req_amount;
          if (req_amount == '0) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_PULSE;
            coin_nx  = pick_coin;
            rem_nx   = req_amount - pick_val;
            sent_nx  = 4'd1;
          end
        end
      end
      ST_PULSE: begin
        if (rem_q == '0) begin
          state_nx = ST_WAIT_RESP;
          tmr_nx   = TIMEOUT_LOAD;
        end else if (resp) begin
          state_nx = ST_SETTLE;
          tmr_nx   = SETTLE_LOAD;
        end else begin
          state_nx = ST_GAP;
          tmr_nx   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (resp) begin
          state_nx = ST_SETTLE;
          tmr_nx   = SETTLE_LOAD;
        end else if (tmr_q == '0) begin
          state_nx = ST_PULSE;
          coin_nx  = pick_coin;
          rem_nx   = rem_q - pick_val;
          sent_nx  = sent_q + 4'd1;
        end else begin
          tmr_nx = tmr_q - 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        if (resp) begin
          state_nx = ST_SETTLE;
          tmr_nx   = SETTLE_LOAD;
        end else if (tmr_q == '0) begin
          state_nx = ST_DONE;
          tmo_nx   = 1'b1;
        end else begin
          tmr_nx = tmr_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) state_nx = ST_DONE;
        else             tmr_nx   = tmr_q - 1'b1;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign coin_in        = coin_q;
  assign done_dispensed = disp_q;
  assign done_returned  = ret_q;
  assign done_timeout   = tmo_q;
  assign change_total   = chg_q;
  assign coins_sent     = sent_q;

endmodule

// File: tb/tb_coin_feeder.sv
// Directed bench for coin_feeder: coin timing checked cycle by cycle, final
// results checked against a scoreboard filled as each request is driven.
module tb_coin_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_amount;
  logic [2:0] coin_in;
  logic       dispense_item, out_return, out_nickel, out_dime;
  logic       busy, done, done_dispensed, done_returned, done_timeout;
  logic [5:0] change_total;
  logic [3:0] coins_sent;

  typedef struct {
    logic       disp;
    logic       ret;
    logic       tmo;
    logic [5:0] chg;
    logic [3:0] sent;
  } res_t;

  res_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   lat;

  always #5 clk = ~clk;

  coin_feeder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_amount     (req_amount),
    .coin_in        (coin_in),
    .dispense_item  (dispense_item),
    .out_return     (out_return),
    .out_nickel     (out_nickel),
    .out_dime       (out_dime),
    .busy           (busy),
    .done           (done),
    .done_dispensed (done_dispensed),
    .done_returned  (done_returned),
    .done_timeout   (done_timeout),
    .change_total   (change_total),
    .coins_sent     (coins_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge while IDLE; returns at the negedge of cycle N+1.
  task automatic accept(input logic [5:0] amt);
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid  = 1'b1;
    req_amount = amt;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic push_exp(input logic d, input logic r, input logic t,
                          input logic [5:0] c, input logic [3:0] s);
    res_t e;
    e.disp = d; e.ret = r; e.tmo = t; e.chg = c; e.sent = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic check_result(input string tag);
    res_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_disp"}, 32'(done_dispensed), 32'(e.disp));
      chk({tag, "_ret"},  32'(done_returned),  32'(e.ret));
      chk({tag, "_tmo"},  32'(done_timeout),   32'(e.tmo));
      chk({tag, "_chg"},  32'(change_total),   32'(e.chg));
      chk({tag, "_sent"}, 32'(coins_sent),     32'(e.sent));
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_amount = '0;
    dispense_item = 1'b0; out_return = 1'b0; out_nickel = 1'b0; out_dime = 1'b0;
    step(2);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_coin",  32'(coin_in), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_flags", 32'({done_dispensed, done_returned, done_timeout}), 0);
    chk("rst_chg",   32'(change_total), 0);
    chk("rst_sent",  32'(coins_sent), 0);
    rst_n = 1'b1;
    step(2);

    // amount 3: dime, 4 idle cycles, nickel, dispense 2 cycles after last coin
    push_exp(1'b1, 1'b0, 1'b0, 6'd0, 4'd2);
    accept(6'd3);
    chk("a_coin1", 32'(coin_in), 32'h2);
    chk("a_busy",  32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("a_gap", 32'(coin_in), 0);
    end
    step(1);
    chk("a_coin2", 32'(coin_in), 32'h1);
    step(1);
    chk("a_wait_coin", 32'(coin_in), 0);
    step(1);
    dispense_item = 1'b1;
    step(1);
    dispense_item = 1'b0;
    wait_done(30, lat);
    chk("a_latency", 32'(lat), 4);
    check_result("a");
    step(1);
    chk("a_done_clr", 32'(done), 0);
    chk("a_hold", 32'(done_dispensed), 1);

    // amount 7: quarter then dime; dime and nickel change during SETTLE
    push_exp(1'b1, 1'b0, 1'b0, 6'd3, 4'd2);
    accept(6'd7);
    chk("b_coin1", 32'(coin_in), 32'h4);
    chk("b_flags_clr", 32'(done_dispensed), 0);
    step(5);
    chk("b_coin2", 32'(coin_in), 32'h2);
    step(1);
    dispense_item = 1'b1;
    step(1);
    dispense_item = 1'b0; out_dime = 1'b1;
    step(1);
    out_dime = 1'b0; out_nickel = 1'b1;
    step(1);
    out_nickel = 1'b0;
    wait_done(30, lat);
    chk("b_latency", 32'(lat), 2);
    check_result("b");
    step(1);

    // amount 4: two dimes, no response -> timeout
    push_exp(1'b0, 1'b0, 1'b1, 6'd0, 4'd2);
    accept(6'd4);
    chk("c_coin1", 32'(coin_in), 32'h2);
    step(5);
    chk("c_coin2", 32'(coin_in), 32'h2);
    wait_done(40, lat);
    chk("c_latency", 32'(lat), 17);
    check_result("c");
    step(1);

    // amount 6: quarter, dispense during the first gap stops the nickel
    push_exp(1'b1, 1'b0, 1'b0, 6'd0, 4'd1);
    accept(6'd6);
    chk("d_coin1", 32'(coin_in), 32'h4);
    step(1);
    chk("d_gap", 32'(coin_in), 0);
    step(1);
    dispense_item = 1'b1;
    step(1);
    dispense_item = 1'b0;
    chk("d_no_coin", 32'(coin_in), 0);
    wait_done(30, lat);
    chk("d_latency", 32'(lat), 4);
    check_result("d");
    step(1);

    // zero amount: immediate done with all flags clear
    push_exp(1'b0, 1'b0, 1'b0, 6'd0, 4'd0);
    accept(6'd0);
    chk("z_done", 32'(done), 1);
    chk("z_coin", 32'(coin_in), 0);
    check_result("z");
    step(1);
    chk("z_done_clr", 32'(done), 0);
    chk("z_ready", 32'(req_ready), 1);

    // amount 9 (3 coins): reset during the second gap aborts
    accept(6'd9);
    chk("r_coin1", 32'(coin_in), 32'h4);
    step(5);
    chk("r_coin2", 32'(coin_in), 32'h2);
    req_valid = 1'b1; req_amount = 6'd1;
    chk("r_busy_ready", 32'(req_ready), 0);
    step(2);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("r_coin_rst", 32'(coin_in), 0);
    chk("r_busy_rst", 32'(busy), 0);
    chk("r_ready_rst", 32'(req_ready), 1);
    chk("r_sent_rst", 32'(coins_sent), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("r_no_done", 32'(done), 0);
    end

    // amount 1 after reset: dispense, return and both change coins together
    push_exp(1'b1, 1'b1, 1'b0, 6'd3, 4'd1);
    accept(6'd1);
    chk("f_coin1", 32'(coin_in), 32'h1);
    step(1);
    dispense_item = 1'b1; out_return = 1'b1; out_nickel = 1'b1; out_dime = 1'b1;
    step(1);
    dispense_item = 1'b0; out_return = 1'b0; out_nickel = 1'b0; out_dime = 1'b0;
    wait_done(30, lat);
    chk("f_latency", 32'(lat), 4);
    check_result("f");
    step(1);
    chk("f_idle", 32'(busy), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
